// File: rtl/tm1638_stimulus_pattern.sv
// Frame source for a TM1638 driver (FIXED / hex COUNT / WALKing bit / BLINK); frame built STIMUL_CLK_CYCLES_DELAY+1
// falling edges after reset or the previous accept, then held with o_Valid high until a falling edge samples i_Ready.
package tm1638_types;
  typedef logic [7:0][7:0] segments_t;
  typedef logic [7:0]      leds_t;
endpackage

package tm1638_driver_types;
  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_WALK  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;
endpackage

module tm1638_stimulus_pattern
  import tm1638_types::*;
  import tm1638_driver_types::*;
#(
  parameter int         STIMUL_CLK_CYCLES_DELAY = 0,
  parameter int         NUM_GRIDS               = 8,
  parameter logic [7:0] SEG                     = 8'h00,
  parameter logic [7:0] LEDS                    = 8'h00
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [1:0] i_Mode,
  input  logic       i_Ready,
  output segments_t  o_Segments,
  output leds_t      o_Leds,
  output logic       o_Valid
);

  if (NUM_GRIDS < 1 || NUM_GRIDS > 8) begin : g_bad_num_grids
    $fatal(1, "tm1638_stimulus_pattern: NUM_GRIDS must be in 1..8");
  end

  localparam int         CNT_W     = (NUM_GRIDS < 1) ? 4 : NUM_GRIDS * 4;
  localparam int         POS_MAX   = NUM_GRIDS * 8 - 1;
  localparam int         DLY_W     = $clog2(STIMUL_CLK_CYCLES_DELAY + 2);
  localparam logic [7:0] GRID_MASK = 8'((16'h1 << NUM_GRIDS) - 16'h1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]       state;
  logic [DLY_W-1:0] dly_cnt;
  logic [CNT_W-1:0] count;
  logic [5:0]       pos;
  logic             phase_on;
  logic [1:0]       prev_mode;

  logic             mode_change;
  logic [CNT_W-1:0] eff_count;
  logic [5:0]       eff_pos;
  logic             eff_phase;
  logic [31:0]      count32;
  segments_t        frame_seg;
  leds_t            frame_led;

  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    case (nib)
      4'h0: return 8'h3F;
      4'h1: return 8'h06;
      4'h2: return 8'h5B;
      4'h3: return 8'h4F;
      4'h4: return 8'h66;
      4'h5: return 8'h6D;
      4'h6: return 8'h7D;
      4'h7: return 8'h07;
      4'h8: return 8'h7F;
      4'h9: return 8'h6F;
      4'hA: return 8'h77;
      4'hB: return 8'h7C;
      4'hC: return 8'h39;
      4'hD: return 8'h5E;
      4'hE: return 8'h79;
      default: return 8'h71;
    endcase
  endfunction

  // A mode switch restarts the pattern before the frame is built from it
  assign mode_change = (i_Mode != prev_mode);
  assign eff_count   = mode_change ? '0 : count;
  assign eff_pos     = mode_change ? 6'd0 : pos;
  assign eff_phase   = mode_change ? 1'b1 : phase_on;
  assign count32     = 32'(eff_count);

  always_comb begin
    frame_seg = '0;
    frame_led = '0;
    for (int g = 0; g < 8; g++) begin
      if (g < NUM_GRIDS) begin
        case (i_Mode)
          MODE_FIXED: frame_seg[g] = SEG;
          MODE_COUNT: frame_seg[g] = hex_digit(4'(count32 >> (4 * (NUM_GRIDS - 1 - g))));
          MODE_WALK:  frame_seg[g] = (eff_pos[5:3] == 3'(g)) ? (8'h01 << eff_pos[2:0]) : 8'h00;
          default:    frame_seg[g] = eff_phase ? SEG : 8'h00;
        endcase
      end
    end
    case (i_Mode)
      MODE_FIXED: frame_led = LEDS & GRID_MASK;
      MODE_COUNT: frame_led = count32[7:0] & GRID_MASK;
      MODE_WALK:  frame_led = 8'h01 << eff_pos[5:3];
      default:    frame_led = eff_phase ? (LEDS & GRID_MASK) : 8'h00;
    endcase
  end

  always_ff @(negedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= ST_IDLE;
      dly_cnt    <= '0;
      count      <= '0;
      pos        <= '0;
      phase_on   <= 1'b1;
      prev_mode  <= MODE_FIXED;
      o_Valid    <= 1'b0;
      o_Segments <= '0;
      o_Leds     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dly_cnt == DLY_W'(STIMUL_CLK_CYCLES_DELAY)) begin
            state      <= ST_PRESENT;
            dly_cnt    <= '0;
            o_Valid    <= 1'b1;
            o_Segments <= frame_seg;
            o_Leds     <= frame_led;
            prev_mode  <= i_Mode;
            count      <= eff_count;
            pos        <= eff_pos;
            phase_on   <= eff_phase;
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        default: begin
          if (i_Ready) begin
            state   <= ST_IDLE;
            o_Valid <= 1'b0;
            // Advance the pattern of the frame just accepted
            case (prev_mode)
              MODE_COUNT: count    <= count + CNT_W'(1);
              MODE_WALK:  pos      <= (pos == 6'(POS_MAX)) ? 6'd0 : pos + 6'd1;
              MODE_BLINK: phase_on <= !phase_on;
              default:    ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_stimulus_pattern.sv
// Bench for tm1638_stimulus_pattern: three instances (FIXED/BLINK timing, COUNT with backpressure and reset, WALK),
// expected frames queued by the stimulus and popped by per-instance monitors on each accepted frame.
`timescale 1ns/1ps
module tb_tm1638_stimulus_pattern;
  import tm1638_types::*;
  import tm1638_driver_types::*;

  typedef struct packed {
    logic [63:0] seg;
    logic [7:0]  led;
  } frame_t;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic      rst_a, rst_b, rst_c;
  logic      rdy_a, rdy_b, rdy_c;
  logic [1:0] mode_a, mode_b, mode_c;
  segments_t seg_a, seg_b, seg_c;
  leds_t     led_a, led_b, led_c;
  logic      va, vb, vc;

  tm1638_stimulus_pattern #(.STIMUL_CLK_CYCLES_DELAY(2), .NUM_GRIDS(8), .SEG(8'hA5), .LEDS(8'h3C)) dut_a (
    .i_Clk(clk), .i_Rst_n(rst_a), .i_Mode(mode_a), .i_Ready(rdy_a),
    .o_Segments(seg_a), .o_Leds(led_a), .o_Valid(va));
  tm1638_stimulus_pattern #(.STIMUL_CLK_CYCLES_DELAY(0), .NUM_GRIDS(2), .SEG(8'h5A), .LEDS(8'hFF)) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_b), .i_Mode(mode_b), .i_Ready(rdy_b),
    .o_Segments(seg_b), .o_Leds(led_b), .o_Valid(vb));
  tm1638_stimulus_pattern #(.STIMUL_CLK_CYCLES_DELAY(1), .NUM_GRIDS(3), .SEG(8'h00), .LEDS(8'h00)) dut_c (
    .i_Clk(clk), .i_Rst_n(rst_c), .i_Mode(mode_c), .i_Ready(rdy_c),
    .o_Segments(seg_c), .o_Leds(led_c), .o_Valid(vc));

  logic [7:0] hex_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  frame_t q_a[$], q_b[$], q_c[$];
  frame_t ea, eb, ec, hold_exp;
  int n_chk = 0;
  int n_pass = 0;
  int edge_n, nr;
  int rises [3];
  logic prev_v;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic frame_t mk(input logic [63:0] s, input logic [7:0] l);
    frame_t f;
    f.seg = s;
    f.led = l;
    return f;
  endfunction

  // Two-grid COUNT frame: grid 0 carries the high nibble
  function automatic frame_t count_frame(input logic [7:0] c);
    return mk({48'h0, hex_tbl[c[3:0]], hex_tbl[c[7:4]]}, c & 8'h03);
  endfunction

  function automatic frame_t walk_frame(input int p);
    return mk(64'h1 << p, 8'h01 << (p / 8));
  endfunction

  function automatic int qsize(input int which);
    case (which)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic cur_valid(input int which);
    case (which)
      0: return va;
      1: return vb;
      default: return vc;
    endcase
  endfunction

  task automatic drain(input int which, input string name);
    int guard = 0;
    while (qsize(which) != 0 && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    check(name, 80'(qsize(which)), 80'd0);
  endtask

  task automatic wait_valid(input int which, input string name);
    int guard = 0;
    while (!cur_valid(which) && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    check(name, 80'(cur_valid(which)), 80'd1);
  endtask

  task automatic accept_b();
    wait_valid(1, "b_wait_valid");
    rdy_b = 1'b1;
    @(negedge clk); #1;
    rdy_b = 1'b0;
  endtask

  // Monitors: compare every frame the DUT hands over (valid and ready at the falling edge to come)
  always @(posedge clk) begin
    if (va && rdy_a) begin
      if (q_a.size() == 0) begin
        n_chk++;
        $display("FAIL a_extra_frame: got seg %h led %h, no frame expected", seg_a, led_a);
      end else begin
        ea = q_a.pop_front();
        check("a_frame", {seg_a, led_a}, {ea.seg, ea.led});
      end
    end
  end

  always @(posedge clk) begin
    if (vb && rdy_b) begin
      if (q_b.size() == 0) begin
        n_chk++;
        $display("FAIL b_extra_frame: got seg %h led %h, no frame expected", seg_b, led_b);
      end else begin
        eb = q_b.pop_front();
        check("b_frame", {seg_b, led_b}, {eb.seg, eb.led});
      end
    end
  end

  always @(posedge clk) begin
    if (vc && rdy_c) begin
      if (q_c.size() == 0) begin
        n_chk++;
        $display("FAIL c_extra_frame: got seg %h led %h, no frame expected", seg_c, led_c);
      end else begin
        ec = q_c.pop_front();
        check("c_frame", {seg_c, led_c}, {ec.seg, ec.led});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    mode_a = MODE_FIXED; mode_b = MODE_COUNT; mode_c = MODE_WALK;
    rises[0] = 0; rises[1] = 0; rises[2] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("a_reset", {seg_a, led_a, 7'b0, va}, 80'd0);
    check("b_reset", {seg_b, led_b, 7'b0, vb}, 80'd0);
    check("c_reset", {seg_c, led_c, 7'b0, vc}, 80'd0);

    // Instance A: FIXED timing, then BLINK restarting at phase ON
    for (int i = 0; i < 3; i++) q_a.push_back(mk({8{8'hA5}}, 8'h3C));
    q_a.push_back(mk({8{8'hA5}}, 8'h3C));
    q_a.push_back(mk(64'h0, 8'h00));
    q_a.push_back(mk({8{8'hA5}}, 8'h3C));
    q_a.push_back(mk(64'h0, 8'h00));
    rdy_a = 1'b1;
    rst_a = 1'b1;
    edge_n = 0; nr = 0; prev_v = 1'b0;
    while (nr < 3 && edge_n < 40) begin
      @(negedge clk); #1;
      edge_n++;
      if (va && !prev_v) begin
        rises[nr] = edge_n;
        nr++;
      end
      prev_v = va;
    end
    mode_a = MODE_BLINK;
    check("a_first_rise_edge", 80'(rises[0]), 80'd3);
    check("a_period_1", 80'(rises[1] - rises[0]), 80'd4);
    check("a_period_2", 80'(rises[2] - rises[1]), 80'd4);
    drain(0, "a_drain");
    rdy_a = 1'b0;

    // Instance B: full 8-bit COUNT sweep including the wrap back to 00
    for (int c = 0; c < 257; c++) q_b.push_back(count_frame(8'(c)));
    rdy_b = 1'b1;
    rst_b = 1'b1;
    drain(1, "b_drain_sweep");
    rdy_b = 1'b0;

    // Backpressure: count 1 held for 10 cycles, then advances exactly once
    wait_valid(1, "b_bp_valid");
    hold_exp = count_frame(8'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      check("b_hold", {seg_b, led_b, 7'b0, vb}, {hold_exp.seg, hold_exp.led, 8'h01});
    end
    q_b.push_back(count_frame(8'd1));
    q_b.push_back(count_frame(8'd2));
    @(negedge clk); #1;
    rdy_b = 1'b1;
    @(negedge clk); #1;
    check("b_valid_drop", 80'(vb), 80'd0);
    rdy_b = 1'b0;
    accept_b();
    q_b.push_back(count_frame(8'd3));
    accept_b();
    q_b.push_back(count_frame(8'd4));
    accept_b();

    // Mode switch COUNT -> BLINK -> COUNT after count 5
    q_b.push_back(count_frame(8'd5));
    wait_valid(1, "b_count5_valid");
    mode_b = MODE_BLINK;
    q_b.push_back(mk({48'h0, 8'h5A, 8'h5A}, 8'h03));
    accept_b();
    q_b.push_back(mk(64'h0, 8'h00));
    accept_b();
    wait_valid(1, "b_blink_off_valid");
    mode_b = MODE_COUNT;
    q_b.push_back(count_frame(8'd0));
    accept_b();
    accept_b();

    // Async reset while count 1 is presented: that frame is abandoned
    wait_valid(1, "b_pre_reset_valid");
    #3;
    rst_b = 1'b0;
    #1;
    check("b_async_reset", {seg_b, led_b, 7'b0, vb}, 80'd0);
    q_b.push_back(count_frame(8'd0));
    @(posedge clk); #2;
    rst_b = 1'b1;
    accept_b();
    check("b_queue_empty", 80'(q_b.size()), 80'd0);

    // Instance C: 24-step WALK and its wrap
    for (int p = 0; p < 25; p++) q_c.push_back(walk_frame(p % 24));
    rdy_c = 1'b1;
    rst_c = 1'b1;
    drain(2, "c_drain_walk");
    rdy_c = 1'b0;

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tm1638_stimulus_pattern.md
TM1638_STIMULUS_PATTERN -- requirements
Module: tm1638_stimulus_pattern

Interface
REQ-001 SHALL import tm1638_types and tm1638_driver_types.
REQ-002 SHALL have parameter STIMUL_CLK_CYCLES_DELAY, default 0: idle cycles before each frame is presented.
REQ-003 SHALL have parameter NUM_GRIDS, default 8: populated grids, legal range 1..8.
REQ-004 SHALL have parameter SEG, default 8'h00: segment byte for FIXED and BLINK modes.
REQ-005 SHALL have parameter LEDS, default 8'h00: LED byte for FIXED and BLINK modes.
REQ-006 SHALL have port i_Clk, input, 1 bit: single clock; all state updates occur on its falling edge.
REQ-007 SHALL have port i_Rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port i_Mode, input, 2 bits: 0 FIXED, 1 COUNT, 2 WALK, 3 BLINK.
REQ-009 SHALL have port i_Ready, input, 1 bit: the driver accepts the current frame.
REQ-010 SHALL have port o_Segments, output, segments_t: o_Segments[g] is the segment byte of grid g.
REQ-011 SHALL have port o_Leds, output, leds_t: o_Leds[g] is the LED above grid g.
REQ-012 SHALL have port o_Valid, output, 1 bit: frame on o_Segments/o_Leds is valid.

Function
REQ-013 SHALL have states IDLE and PRESENT.
- IDLE: the delay counter counts 0..STIMUL_CLK_CYCLES_DELAY.
- IDLE -> PRESENT: on the edge where count == STIMUL_CLK_CYCLES_DELAY. On that edge the frame is built, o_Valid is set to 1 and the counter is cleared.
REQ-014 In PRESENT, SHALL hold o_Valid, o_Segments and o_Leds stable until a falling edge samples i_Ready=1.
- On that edge: o_Valid goes to 0, the pattern state advances, and the state returns to IDLE.
REQ-015 SHALL give a minimum frame period of STIMUL_CLK_CYCLES_DELAY+2 cycles when i_Ready is tied to 1.
REQ-016 SHALL sample i_Mode only on the frame-build edge. If it differs from the mode of the previous frame, the pattern state SHALL restart (count 0, position 0, phase ON) before the frame is built.
REQ-017 SHALL drive grids g >= NUM_GRIDS with segment byte 8'h00 and LED bit 0 in every mode.
REQ-018 FIXED SHALL output SEG on every populated grid and LEDS masked to the populated grids. Its pattern state does not change.
REQ-019 COUNT SHALL keep a NUM_GRIDS*4-bit counter and display it in hex.
- Grid g shows nibble (NUM_GRIDS-1-g), so grid 0 shows the most significant nibble.
- Segment bits a..g map to bits 0..6; dp (bit 7) is 0.
- Digit codes 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-020 COUNT SHALL set o_Leds to the counter's low 8 bits, masked to the populated grids. The counter increments on accept and wraps from all-ones to 0.
REQ-021 WALK SHALL keep a position p in 0..NUM_GRIDS*8-1.
- Only bit p mod 8 of grid p/8 is 1, and only LED p/8 is 1.
- p increments on accept and wraps from NUM_GRIDS*8-1 to 0.
REQ-022 BLINK SHALL toggle a phase on each accept. Phase ON outputs as FIXED; phase OFF outputs all-zero segments and LEDs.
REQ-023 SHALL not assert o_Valid on two consecutive frames without an intervening IDLE cycle.
REQ-024 SHALL reject an illegal NUM_GRIDS (0 or >8) at elaboration with a fatal error.

Reset
REQ-025 SHALL, while i_Rst_n=0 and independent of the clock, hold o_Valid=0, o_Segments=64'h0, o_Leds=8'h0, state IDLE, delay count 0, counter 0, position 0, phase ON and the previous-mode register at FIXED.
REQ-026 SHALL abandon a frame in PRESENT if reset asserts mid-frame, with no accept recorded. After release, operation restarts from REQ-013.

Verification
REQ-027 FIXED, DELAY=2, SEG=8'hA5, LEDS=8'h3C, NUM_GRIDS=8, i_Ready=1 -> o_Valid rises on the 3rd falling edge after reset release with {8{8'hA5}} and 8'h3C, then pulses every 4 cycles.
REQ-028 COUNT, NUM_GRIDS=2, DELAY=0, i_Ready=1 -> frames show 3F3F, 3F06, ... 7171, then wrap to 3F3F. Grids 2-7 stay 00; LEDs follow count&8'h03.
REQ-029 WALK, NUM_GRIDS=3 -> 24 frames with a single set bit stepping grid0 bit0 .. grid2 bit7, then back to grid0 bit0. LED index equals the grid index.
REQ-030 Backpressure: i_Ready=0 for 10 cycles after o_Valid rises -> outputs stable for all 10 cycles. One cycle after i_Ready=1, o_Valid falls and the pattern advances exactly once.
REQ-031 Mode switch COUNT->BLINK after count 5, then back to COUNT -> BLINK starts at phase ON and COUNT restarts at 0.
REQ-032 Async reset pulse between clock edges while in PRESENT -> outputs are zero immediately. The first frame after release is the initial pattern.
